timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
//   Controller that drives the enable/timer_load/timeout interface of the down-count timer.
//   Software-side requests arrive over a valid/ready handshake. Each request carries a load
//   value and a repeat count. The block arms the timer, runs it, and collects timeout. It then
//   re-arms for the remaining repeats and reports expiries, completion and watchdog faults.
//   It sits between the control/register logic and one timer instance.
// PARAMETERS
//   W      32  width of load value and tmr_load/tmr_value
//   RW      8  width of repeat count and expire_count
//   GUARD   4  extra RUN cycles beyond the load value before the watchdog fires (>=3)
// PORTS
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous reset, active-high
//   req_valid     in   1   request present
//   req_ready     out  1   high in IDLE only; transfer when req_valid & req_ready
//   req_load      in   W   timer load value for this request
//   req_repeat    in   RW  number of timer periods; 0 is treated as 1
//   abort         in   1   cancel the active request
//   tmr_enable    out  1   to timer enable
//   tmr_load      out  W   to timer timer_load; holds the captured req_load
//   tmr_timeout   in   1   from timer timeout (registered in the timer)
//   tmr_value     in   W   from timer timervalue; sampled into last_value
//   busy          out  1   state != IDLE
//   expire_pulse  out  1   1-cycle pulse per collected timeout
//   done_pulse    out  1   1-cycle pulse when all repeats complete normally
//   error         out  1   sticky watchdog flag; cleared by the next accepted request
//   expire_count  out  RW  timeouts collected in the current request
//   last_value    out  W   tmr_value captured on the cycle each timeout is collected
// BEHAVIOUR
//   Reset values: state=IDLE, tmr_enable=0, tmr_load=0, all pulses 0, error=0,
//     expire_count=0, last_value=0, and req_ready=1 after reset deassert.
//   All outputs are registered except req_ready and busy, which decode the state directly.
//   States: IDLE, LOAD, RUN.
//   IDLE:
//     - On handshake: capture load into tmr_load, capture remaining=max(repeat,1).
//     - Clear expire_count and error, then go to LOAD.
//   LOAD (exactly 1 cycle, tmr_enable=0): the timer latches timer_load and clears timeout.
//     - Next state is RUN. Clear the watchdog counter wd.
//   RUN (tmr_enable=1): wd increments each cycle, saturating.
//     - When tmr_timeout=1: pulse expire_pulse, expire_count+=1, last_value<=tmr_value,
//       remaining-=1.
//     - If remaining was 1: go to IDLE and pulse done_pulse in the same cycle as
//       expire_pulse. Otherwise go to LOAD (re-arm).
//     - Watchdog: if wd == tmr_load+GUARD and no timeout that cycle: error<=1, go to IDLE,
//       no done_pulse. The add is done at W+1 bits, so load=max does not wrap.
//   tmr_enable drops in the cycle after the timeout is collected. The timer therefore sees
//     enable low and clears timeout before the next RUN.
//   abort:
//     - In LOAD/RUN: go to IDLE next cycle, tmr_enable=0, no done_pulse, no expire for
//       that cycle, error unchanged.
//     - abort has priority over a simultaneous timeout.
//     - Ignored in IDLE.
//   A new request cannot be accepted in the cycle the block returns to IDLE. req_ready rises
//     the following cycle.
//   expire_count saturates at all-ones. The repeat decrement never underflows.
//   Reset mid-operation forces IDLE immediately (async) and tmr_enable=0.
//   tmr_load holds its value in IDLE (not cleared) so the timer keeps a stable load input.
// TESTING
//   1 Reset: assert rst mid-RUN -> tmr_enable=0, busy=0 and pulses 0 without waiting for a
//     clock edge; req_ready=1 after deassert.
//   2 Single: load=5, repeat=1 -> one LOAD, RUN; expire_pulse & done_pulse together within
//     5+GUARD cycles of RUN entry; expire_count=1, last_value=0.
//   3 Repeat: load=3, repeat=4 -> 4 expire_pulses, each separated by exactly one tmr_enable=0
//     cycle; done_pulse with the 4th; expire_count=4.
//   4 Repeat=0 and load=0 -> treated as 1 period; timeout within 2 RUN cycles; done_pulse.
//   5 Watchdog: timer model holds timeout=0, load=10 -> error=1 after 10+GUARD RUN cycles;
//     IDLE; no done_pulse; the next request clears error.
//   6 Abort in RUN with tmr_timeout=1 the same cycle -> IDLE next cycle, no expire_pulse or
//     done_pulse; req_valid held high is accepted one cycle later.

Source files
------------

// File: rtl/timer_sequencer.sv
// Request sequencer for a down-count timer: accepts load/repeat requests, arms and runs the
// timer once per period, collects timeouts, and guards each period with a watchdog.
module timer_sequencer #(
   parameter int W     = 32,
   parameter int RW    = 8,
   parameter int GUARD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [W-1:0]  req_load,
   input  logic [RW-1:0] req_repeat,
   input  logic          abort,
   output logic          tmr_enable,
   output logic [W-1:0]  tmr_load,
   input  logic          tmr_timeout,
   input  logic [W-1:0]  tmr_value,
   output logic          busy,
   output logic          expire_pulse,
   output logic          done_pulse,
   output logic          error,
   output logic [RW-1:0] expire_count,
   output logic [W-1:0]  last_value
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   state_t        state, state_nxt;
   logic [RW-1:0] remaining;
   logic [W:0]    wd, wd_limit;
   logic          accept, collect, wd_fire, last_period;

   assign req_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign accept      = req_valid & req_ready;
   // One extra bit so a maximal load plus the guard band cannot wrap.
   assign wd_limit    = {1'b0, tmr_load} + (W+1)'(GUARD);
   assign collect     = (state == RUN) & tmr_timeout & ~abort;
   assign wd_fire     = (state == RUN) & ~tmr_timeout & ~abort & (wd == wd_limit);
   assign last_period = (remaining <= RW'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = LOAD;
         LOAD:    state_nxt = abort ? IDLE : RUN;
         RUN: begin
            if (abort || wd_fire) state_nxt = IDLE;
            else if (tmr_timeout) state_nxt = last_period ? IDLE : LOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_enable   <= 1'b0;
         tmr_load     <= '0;
         remaining    <= '0;
         wd           <= '0;
         expire_pulse <= 1'b0;
         done_pulse   <= 1'b0;
         error        <= 1'b0;
         expire_count <= '0;
         last_value   <= '0;
      end else begin
         // Enable follows the state we are entering, so it is low for every LOAD cycle.
         tmr_enable   <= (state_nxt == RUN);
         expire_pulse <= collect;
         done_pulse   <= collect & last_period;
         if (accept) begin
            tmr_load     <= req_load;
            remaining    <= (req_repeat == '0) ? RW'(1) : req_repeat;
            expire_count <= '0;
            error        <= 1'b0;
         end
         if (state == LOAD)                   wd <= '0;
         else if (state == RUN && wd != '1)   wd <= wd + 1'b1;
         if (collect) begin
            if (expire_count != '1) expire_count <= expire_count + 1'b1;
            if (remaining != '0)    remaining    <= remaining - 1'b1;
            last_value <= tmr_value;
         end
         if (wd_fire) error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// Bench for timer_sequencer: behavioural down-count timer, directed and random requests,
// expected events queued at issue time and matched by an independent monitor.
module tb_timer_sequencer;
   localparam int W = 32, RW = 8, GUARD = 4;

   logic          clk = 0, rst = 1;
   logic          req_valid = 0, abort = 0;
   logic [W-1:0]  req_load = '0;
   logic [RW-1:0] req_repeat = '0;
   logic          req_ready, tmr_enable, busy, expire_pulse, done_pulse, error;
   logic [W-1:0]  tmr_load, last_value;
   logic [RW-1:0] expire_count;

   logic [W-1:0]  tval = '0;
   logic          tout = 1'b0;
   bit            stuck = 0;

   int n_checks = 0, n_fail = 0;
   int cyc = 0;
   bit err_q = 0;

   typedef struct {bit is_err; bit is_done; int at; int cnt;} exp_t;
   exp_t sb[$];

   timer_sequencer #(.W(W), .RW(RW), .GUARD(GUARD)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_repeat(req_repeat), .abort(abort),
      .tmr_enable(tmr_enable), .tmr_load(tmr_load), .tmr_timeout(tout), .tmr_value(tval),
      .busy(busy), .expire_pulse(expire_pulse), .done_pulse(done_pulse), .error(error),
      .expire_count(expire_count), .last_value(last_value));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Down-count timer: loads while disabled, counts to zero, then raises a registered timeout.
   always @(posedge clk) begin
      if (!tmr_enable) begin
         tval <= tmr_load;
         tout <= 1'b0;
      end else if (tval == '0) tout <= !stuck;
      else tval <= tval - 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Request accepted at edge a: period k is collected at edge a+k*(l+3), the pulse is seen
   // right after it; a stuck timer trips the watchdog at edge a+l+GUARD+2. Abort at edge
   // a+pa_off suppresses everything from that edge on.
   function automatic void push_exp(int a, int l, int r, bit stk, int pa_off);
      int   n = (r == 0) ? 1 : r;
      exp_t e;
      if (stk) begin
         if (pa_off == 0 || l + GUARD + 2 < pa_off) begin
            e.is_err = 1; e.is_done = 0; e.at = a + l + GUARD + 2; e.cnt = 0;
            sb.push_back(e);
         end
      end else begin
         for (int k = 1; k <= n; k++) begin
            if (pa_off != 0 && k * (l + 3) >= pa_off) break;
            e.is_err = 0; e.is_done = (k == n); e.at = a + k * (l + 3);
            e.cnt = (k > 255) ? 255 : k;
            sb.push_back(e);
         end
      end
   endfunction

   always @(negedge clk) begin
      bit   err_rise;
      exp_t e;
      err_rise = error && !err_q;
      if (!rst && (expire_pulse || done_pulse || err_rise)) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_event: cycle %0d expire=%0b done=%0b error_rise=%0b, required no event",
                     cyc, expire_pulse, done_pulse, err_rise);
         end else begin
            e = sb.pop_front();
            check("evt_cycle", cyc, e.at);
            check("evt_expire", expire_pulse, !e.is_err);
            check("evt_done", done_pulse, e.is_done);
            check("evt_error", err_rise, e.is_err);
            check("evt_count", expire_count, e.cnt);
            if (!e.is_err) check("evt_last_value", last_value, 0);
         end
      end
      err_q = error;
   end

   task automatic wait_cyc(input int target);
      int g = 0;
      while (cyc < target && g < 2000) begin @(negedge clk); g++; end
      check("wait_cyc_timeout", (cyc >= target), 1);
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 500) begin @(negedge clk); g++; end
      check("idle_timeout", busy, 0);
   endtask

   task automatic start_req(input int l, input int r, input bit stk, input int pa_off,
                            output int a);
      int g = 0;
      req_load = l; req_repeat = r[RW-1:0]; req_valid = 1; stuck = stk;
      while (!req_ready && g < 50) begin @(negedge clk); g++; end
      check("req_ready", req_ready, 1);
      a = cyc + 1;
      push_exp(a, l, r, stk, pa_off);
      @(negedge clk);
      req_valid = 0;
      check("busy_on_accept", busy, 1);
      check("error_cleared", error, 0);
      check("count_cleared", expire_count, 0);
      check("tmr_load", tmr_load, l);
   endtask

   task automatic run_req(input int l, input int r, input bit stk, input int pa_off);
      int a;
      start_req(l, r, stk, pa_off, a);
      if (pa_off != 0) begin
         wait_cyc(a + pa_off - 1);
         abort = 1;
         @(negedge clk);
         abort = 0;
         check("abort_idle", busy, 0);
         check("abort_enable", tmr_enable, 0);
      end else wait_idle();
      stuck = 0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, l, r, m, n;
      repeat (3) @(negedge clk);
      check("rst_enable", tmr_enable, 0);
      check("rst_busy", busy, 0);
      rst = 0;
      @(negedge clk);
      check("rst_ready", req_ready, 1);
      check("rst_count", expire_count, 0);
      check("rst_last", last_value, 0);
      check("rst_error", error, 0);
      check("rst_load", tmr_load, 0);

      run_req(5, 1, 0, 0);    // single period
      run_req(3, 4, 0, 0);    // repeated periods
      check("repeat_count", expire_count, 4);
      run_req(0, 0, 0, 0);    // repeat 0 and load 0 behave as one short period
      run_req(10, 1, 1, 0);   // watchdog
      check("error_sticky", error, 1);
      check("wd_count", expire_count, 0);
      run_req(2, 2, 0, 0);    // clears error

      // Abort on the cycle the timeout is presented, with the next request already waiting.
      start_req(4, 2, 0, 7, a);
      wait_cyc(a + 6);
      check("ready_in_run", req_ready, 0);
      abort = 1; req_load = 2; req_repeat = 1; req_valid = 1;
      @(negedge clk);
      abort = 0;
      check("abort_busy", busy, 0);
      check("abort_enable", tmr_enable, 0);
      check("abort_ready", req_ready, 1);
      push_exp(cyc + 1, 2, 1, 0, 0);
      @(negedge clk);
      req_valid = 0;
      check("reaccept_busy", busy, 1);
      check("reaccept_load", tmr_load, 2);
      wait_idle();
      @(negedge clk);

      for (int i = 0; i < 25; i++) begin
         l = $urandom_range(0, 7);
         r = $urandom_range(0, 4);
         m = $urandom_range(0, 9);
         n = (r == 0) ? 1 : r;
         if (m < 6)      run_req(l, r, 0, 0);
         else if (m < 8) run_req(l, r, 0, $urandom_range(1, n * (l + 3)));
         else            run_req(l, r, 1, 0);
      end

      // Asynchronous reset in the middle of a run.
      start_req(5, 3, 0, 0, a);
      wait_cyc(a + 12);
      check("pre_rst_enable", tmr_enable, 1);
      #2 rst = 1;
      #1;
      check("async_rst_enable", tmr_enable, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_expire", expire_pulse, 0);
      check("async_rst_done", done_pulse, 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("post_rst_ready", req_ready, 1);
      check("post_rst_count", expire_count, 0);
      check("post_rst_load", tmr_load, 0);
      run_req(1, 2, 0, 0);

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
